// File: rtl/rgb_mixer.sv
// Three-channel RGB mixer: each quadrature encoder is synchronised, debounced and decoded
// into an 8-bit level that sets the duty cycle of one PWM output.
module rgb_mixer #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEBOUNCE_LEN = 8,
  parameter int unsigned INCREMENT    = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enc0_a,
  input  logic enc0_b,
  input  logic enc1_a,
  input  logic enc1_b,
  input  logic enc2_a,
  input  logic enc2_b,
  output logic pwm0_out,
  output logic pwm1_out,
  output logic pwm2_out
);

  localparam int unsigned NumCh = 3;
  localparam int unsigned NumIn = 2 * NumCh;
  localparam logic [WIDTH-1:0] Step = WIDTH'(INCREMENT);

  logic [NumIn-1:0]        enc_raw;
  logic [NumIn-1:0]        sync1_q, sync2_q, deb_q, prev_q;
  logic [DEBOUNCE_LEN-1:0] hist_q  [NumIn];
  logic [WIDTH-1:0]        level_q [NumCh];
  logic [WIDTH-1:0]        level_d [NumCh];
  logic [WIDTH-1:0]        cnt_q;
  logic [NumCh-1:0]        pwm_q;

  // Even bits carry encoder A, odd bits encoder B.
  assign enc_raw = {enc2_b, enc2_a, enc1_b, enc1_a, enc0_b, enc0_a};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      prev_q  <= '0;
      for (int i = 0; i < NumIn; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      sync1_q <= enc_raw;
      sync2_q <= sync1_q;
      prev_q  <= deb_q;
      for (int i = 0; i < NumIn; i++) begin
        hist_q[i] <= {hist_q[i][DEBOUNCE_LEN-2:0], sync2_q[i]};
        if (&hist_q[i]) begin
          deb_q[i] <= 1'b1;
        end else if (~|hist_q[i]) begin
          deb_q[i] <= 1'b0;
        end
      end
    end
  end

  // Pattern {a, pa, b, pb}: count only single-signal edges that advance the quadrature.
  always_comb begin
    for (int c = 0; c < NumCh; c++) begin
      level_d[c] = level_q[c];
      case ({deb_q[2*c], prev_q[2*c], deb_q[2*c+1], prev_q[2*c+1]})
        4'b1000, 4'b0111: level_d[c] = level_q[c] + Step;
        4'b0010, 4'b1101: level_d[c] = level_q[c] - Step;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      pwm_q <= '0;
      for (int c = 0; c < NumCh; c++) begin
        level_q[c] <= '0;
      end
    end else begin
      cnt_q <= cnt_q + 1'b1;
      for (int c = 0; c < NumCh; c++) begin
        level_q[c] <= level_d[c];
        pwm_q[c]   <= (cnt_q < level_q[c]);
      end
    end
  end

  assign pwm0_out = pwm_q[0];
  assign pwm1_out = pwm_q[1];
  assign pwm2_out = pwm_q[2];

endmodule

// File: tb/tb_rgb_mixer.sv
// Scoreboard bench for rgb_mixer: stimulus drives encoder moves and pushes expected levels;
// a monitor counts PWM high cycles over 256-cycle windows and compares.
module tb_rgb_mixer;

  localparam int Hold = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] ea = '0;
  logic [2:0] eb = '0;
  logic       p0, p1, p2;

  int errors = 0;
  int checks = 0;
  int issued = 0;
  int meas_done = 0;

  // Reference model: settled encoder state and level per channel.
  int lvl [3];
  bit ma  [3];
  bit mb  [3];

  logic [23:0] exp_q [$];

  always #5 clk = ~clk;

  rgb_mixer dut (
    .clk     (clk),
    .reset   (reset),
    .enc0_a  (ea[0]),
    .enc0_b  (eb[0]),
    .enc1_a  (ea[1]),
    .enc1_b  (eb[1]),
    .enc2_a  (ea[2]),
    .enc2_b  (eb[2]),
    .pwm0_out(p0),
    .pwm1_out(p1),
    .pwm2_out(p2)
  );

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d high cycles, expected %0d", name, act, exp);
    end
  endfunction

  // A change of only A counts up when A now differs from B; only B counts down when B now
  // differs from A; simultaneous changes do nothing.
  function automatic void apply_model(int ch, bit na, bit nb);
    if (na != ma[ch] && nb == mb[ch]) begin
      if (na != nb) lvl[ch] = (lvl[ch] + 1) % 256;
    end else if (nb != mb[ch] && na == ma[ch]) begin
      if (nb != na) lvl[ch] = (lvl[ch] + 255) % 256;
    end
    ma[ch] = na;
    mb[ch] = nb;
  endfunction

  task automatic move(int ch, bit na, bit nb);
    @(negedge clk);
    ea[ch] = na;
    eb[ch] = nb;
    apply_model(ch, na, nb);
    repeat (Hold) @(negedge clk);
  endtask

  task automatic cw(int ch);
    move(ch, ~mb[ch], ma[ch]);
  endtask

  task automatic ccw(int ch);
    move(ch, mb[ch], ~ma[ch]);
  endtask

  task automatic pulse(int ch, bit on_b, int n);
    bit oa, ob;
    oa = ma[ch];
    ob = mb[ch];
    @(negedge clk);
    if (on_b) eb[ch] = ~ob;
    else      ea[ch] = ~oa;
    repeat (n) @(negedge clk);
    ea[ch] = oa;
    eb[ch] = ob;
    if (n >= 8) begin
      apply_model(ch, on_b ? oa : ~oa, on_b ? ~ob : ob);
      apply_model(ch, oa, ob);
    end
    repeat (Hold) @(negedge clk);
  endtask

  task automatic measure();
    exp_q.push_back({8'(lvl[2]), 8'(lvl[1]), 8'(lvl[0])});
    issued++;
    for (int i = 0; i < 700 && meas_done < issued; i++) @(negedge clk);
    if (meas_done < issued) begin
      checks++;
      errors++;
      $display("FAIL measure_timeout: got %0d windows, expected %0d", meas_done, issued);
    end
  endtask

  // Monitor: any 256 consecutive cycles at a stable level cover every counter value once.
  initial begin
    logic [23:0] e;
    int h0, h1, h2;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        h0 = 0;
        h1 = 0;
        h2 = 0;
        repeat (256) begin
          @(negedge clk);
          h0 += int'(p0);
          h1 += int'(p1);
          h2 += int'(p2);
        end
        check("pwm0_duty", h0, int'(e[7:0]));
        check("pwm1_duty", h1, int'(e[15:8]));
        check("pwm2_duty", h2, int'(e[23:16]));
        meas_done++;
      end
    end
  end

  initial begin
    for (int c = 0; c < 3; c++) begin
      lvl[c] = 0;
      ma[c]  = 1'b0;
      mb[c]  = 1'b0;
    end
    repeat (5) @(negedge clk);
    reset = 1'b0;
    measure();
    measure();

    for (int i = 0; i < 40; i++) cw(0);
    for (int i = 0; i < 8; i++) ccw(1);
    pulse(2, 1'b0, 5);
    measure();
    pulse(2, 1'b0, 9);
    measure();

    while (lvl[0] != 255) cw(0);
    measure();
    while (lvl[0] == 255) cw(0);
    measure();
    while (lvl[0] == 0) cw(0);

    // Reset with all levels non-zero; inputs parked at 00 while held.
    @(negedge clk);
    reset = 1'b1;
    ea = '0;
    eb = '0;
    for (int c = 0; c < 3; c++) begin
      lvl[c] = 0;
      ma[c]  = 1'b0;
      mb[c]  = 1'b0;
    end
    measure();
    @(negedge clk);
    reset = 1'b0;
    repeat (Hold) @(negedge clk);
    for (int i = 0; i < 4; i++) cw(1);
    measure();

    for (int r = 0; r < 6; r++) begin
      int ch, n;
      ch = int'($urandom_range(0, 2));
      n  = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) cw(ch);
        else ccw(ch);
      end
      if ($urandom_range(0, 1) == 1) begin
        pulse(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
              int'($urandom_range(3, 12)));
      end
      measure();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
